// File: rtl/trap_sequencer.sv
// trap_sequencer: multi-cycle trap entry and MRET return sequencer driving CSR writes, flush and PC redirect
module trap_sequencer #(
    parameter int         XLEN       = 64,
    parameter logic [1:0] RESET_PRIV = 2'b11
) (
    input  logic            CLK,
    input  logic            RESET,
    input  logic            TRAP_REQ,
    input  logic [XLEN-1:0] TRAP_CAUSE,
    input  logic [XLEN-1:0] TRAP_PC,
    input  logic [XLEN-1:0] TRAP_TVAL,
    input  logic            MRET_REQ,
    input  logic [XLEN-1:0] MTVEC,
    input  logic [XLEN-1:0] MEPC,
    input  logic [XLEN-1:0] MSTATUS,
    input  logic [1:0]      PRIVILEGE,
    output logic            CSR_WE,
    output logic [11:0]     CSR_ADDR,
    output logic [XLEN-1:0] CSR_WDATA,
    output logic            FLUSH,
    output logic            STALL,
    output logic            PC_REDIRECT,
    output logic [XLEN-1:0] PC_TARGET,
    output logic            PRIV_WE,
    output logic [1:0]      PRIV_NEXT,
    output logic            BUSY
);
    typedef enum logic [3:0] {
        IDLE, T_FLUSH, T_EPC, T_CAUSE, T_TVAL, T_STATUS, T_JUMP, R_STATUS, R_JUMP
    } state_t;

    state_t          state, state_nx;
    logic [XLEN-1:0] cause_q, pc_q, tval_q, mstatus_q, mtvec_q, mepc_q;
    logic [1:0]      priv_q;
    logic            post_rst;
    logic [XLEN-1:0] trap_status, mret_status, base, trap_target;

    // State register and request capture; operands are latched only on acceptance in IDLE
    always_ff @(posedge CLK) begin
        if (RESET) begin
            state     <= IDLE;
            post_rst  <= 1'b1;
            cause_q   <= '0;
            pc_q      <= '0;
            tval_q    <= '0;
            mstatus_q <= '0;
            mtvec_q   <= '0;
            mepc_q    <= '0;
            priv_q    <= '0;
        end else begin
            state    <= state_nx;
            post_rst <= 1'b0;
            if (state == IDLE && TRAP_REQ) begin
                cause_q   <= TRAP_CAUSE;
                pc_q      <= TRAP_PC;
                tval_q    <= TRAP_TVAL;
                mstatus_q <= MSTATUS;
                mtvec_q   <= MTVEC;
                priv_q    <= PRIVILEGE;
            end else if (state == IDLE && MRET_REQ) begin
                mstatus_q <= MSTATUS;
                mepc_q    <= MEPC;
            end
        end
    end

    // Derived CSR images and the trap vector target
    always_comb begin
        trap_status        = mstatus_q;
        trap_status[7]     = mstatus_q[3];
        trap_status[3]     = 1'b0;
        trap_status[12:11] = priv_q;
        mret_status        = mstatus_q;
        mret_status[3]     = mstatus_q[7];
        mret_status[7]     = 1'b1;
        mret_status[12:11] = 2'b00;
        base               = {mtvec_q[XLEN-1:2], 2'b00};
        trap_target        = (mtvec_q[1:0] == 2'b01 && cause_q[XLEN-1]) ? base + {cause_q[XLEN-3:0], 2'b00} : base;
    end

    // Next-state and per-state output strobes; the post-reset privilege restore is the only IDLE strobe
    always_comb begin
        state_nx    = state;
        CSR_WE      = 1'b0;
        CSR_ADDR    = '0;
        CSR_WDATA   = '0;
        FLUSH       = 1'b0;
        PC_REDIRECT = 1'b0;
        PC_TARGET   = '0;
        PRIV_WE     = 1'b0;
        PRIV_NEXT   = 2'b00;
        case (state)
            IDLE: begin
                state_nx  = TRAP_REQ ? T_FLUSH : MRET_REQ ? R_STATUS : IDLE;
                PRIV_WE   = post_rst & ~RESET;
                PRIV_NEXT = (post_rst & ~RESET) ? RESET_PRIV : 2'b00;
            end
            T_FLUSH: begin
                state_nx = T_EPC;
                FLUSH    = 1'b1;
            end
            T_EPC: begin
                state_nx  = T_CAUSE;
                CSR_WE    = 1'b1;
                CSR_ADDR  = 12'h341;
                CSR_WDATA = {pc_q[XLEN-1:2], 2'b00};
            end
            T_CAUSE: begin
                state_nx  = T_TVAL;
                CSR_WE    = 1'b1;
                CSR_ADDR  = 12'h342;
                CSR_WDATA = cause_q;
            end
            T_TVAL: begin
                state_nx  = T_STATUS;
                CSR_WE    = 1'b1;
                CSR_ADDR  = 12'h343;
                CSR_WDATA = tval_q;
            end
            T_STATUS: begin
                state_nx  = T_JUMP;
                CSR_WE    = 1'b1;
                CSR_ADDR  = 12'h300;
                CSR_WDATA = trap_status;
            end
            T_JUMP: begin
                state_nx    = IDLE;
                PC_REDIRECT = 1'b1;
                PC_TARGET   = trap_target;
                PRIV_WE     = 1'b1;
                PRIV_NEXT   = 2'b11;
            end
            R_STATUS: begin
                state_nx  = R_JUMP;
                FLUSH     = 1'b1;
                CSR_WE    = 1'b1;
                CSR_ADDR  = 12'h300;
                CSR_WDATA = mret_status;
            end
            R_JUMP: begin
                state_nx    = IDLE;
                PC_REDIRECT = 1'b1;
                PC_TARGET   = mepc_q;
                PRIV_WE     = 1'b1;
                PRIV_NEXT   = mstatus_q[12:11];
            end
            default: state_nx = IDLE;
        endcase
    end

    assign BUSY  = state != IDLE;
    assign STALL = BUSY;
endmodule

// File: tb/tb_trap_sequencer.sv
// tb_trap_sequencer: scoreboard bench comparing every cycle of trap_sequencer outputs against a reference model
module tb_trap_sequencer;
    logic        CLK = 1'b0;
    logic        RESET = 1'b1;
    logic        TRAP_REQ = 1'b0, MRET_REQ = 1'b0;
    logic [63:0] TRAP_CAUSE = '0, TRAP_PC = '0, TRAP_TVAL = '0;
    logic [63:0] MTVEC = '0, MEPC = '0, MSTATUS = '0;
    logic [1:0]  PRIVILEGE = '0;
    logic        CSR_WE, FLUSH, STALL, PC_REDIRECT, PRIV_WE, BUSY;
    logic [11:0] CSR_ADDR;
    logic [63:0] CSR_WDATA, PC_TARGET;
    logic [1:0]  PRIV_NEXT;

    typedef struct packed {
        logic        busy;
        logic        stall;
        logic        flush;
        logic        we;
        logic [11:0] addr;
        logic [63:0] wdata;
        logic        redir;
        logic [63:0] tgt;
        logic        pwe;
        logic [1:0]  pnext;
    } obs_t;

    obs_t  eq[$];
    string tq[$];
    int    checks = 0, errors = 0;
    logic  mon_en = 1'b0;

    trap_sequencer dut (
        .CLK(CLK), .RESET(RESET), .TRAP_REQ(TRAP_REQ), .TRAP_CAUSE(TRAP_CAUSE),
        .TRAP_PC(TRAP_PC), .TRAP_TVAL(TRAP_TVAL), .MRET_REQ(MRET_REQ), .MTVEC(MTVEC),
        .MEPC(MEPC), .MSTATUS(MSTATUS), .PRIVILEGE(PRIVILEGE), .CSR_WE(CSR_WE),
        .CSR_ADDR(CSR_ADDR), .CSR_WDATA(CSR_WDATA), .FLUSH(FLUSH), .STALL(STALL),
        .PC_REDIRECT(PC_REDIRECT), .PC_TARGET(PC_TARGET), .PRIV_WE(PRIV_WE),
        .PRIV_NEXT(PRIV_NEXT), .BUSY(BUSY)
    );

    always #5 CLK = ~CLK;

    function automatic obs_t mk(input logic busy, input logic flush, input logic we, input logic [11:0] addr,
                                input logic [63:0] wdata, input logic redir, input logic [63:0] tgt,
                                input logic pwe, input logic [1:0] pnext);
        return '{busy, busy, flush, we, addr, wdata, redir, tgt, pwe, pnext};
    endfunction

    task automatic chk(input string tag, input obs_t got, input obs_t exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic push(input string tag, input obs_t o);
        eq.push_back(o);
        tq.push_back(tag);
    endtask

    // Each sampled cycle pops one expectation; with nothing queued the sequencer must be fully quiet
    always @(negedge CLK) begin
        if (mon_en) begin
            obs_t  got, exp;
            string tag;
            got = '{BUSY, STALL, FLUSH, CSR_WE, CSR_ADDR, CSR_WDATA, PC_REDIRECT, PC_TARGET, PRIV_WE, PRIV_NEXT};
            exp = eq.size() != 0 ? eq.pop_front() : mk(0, 0, 0, 12'h0, 64'h0, 0, 64'h0, 0, 2'b00);
            tag = tq.size() != 0 ? tq.pop_front() : "quiet";
            chk(tag, got, exp);
        end
    end

    task automatic scramble();
        TRAP_CAUSE = {$urandom, $urandom};
        TRAP_PC    = {$urandom, $urandom};
        TRAP_TVAL  = {$urandom, $urandom};
        MTVEC      = {$urandom, $urandom};
        MEPC       = {$urandom, $urandom};
        MSTATUS    = {$urandom, $urandom};
        PRIVILEGE  = 2'($urandom);
    endtask

    task automatic drive_trap(input logic [63:0] cause, input logic [63:0] pc, input logic [63:0] tval,
                              input logic [63:0] mtvec, input logic [63:0] ms, input logic [1:0] priv,
                              input logic with_mret);
        logic [63:0] st, base, tgt;
        TRAP_REQ = 1'b1; MRET_REQ = with_mret;
        TRAP_CAUSE = cause; TRAP_PC = pc; TRAP_TVAL = tval; MTVEC = mtvec; MSTATUS = ms; PRIVILEGE = priv;
        MEPC = {$urandom, $urandom};
        st   = (ms & ~64'h1888) | ({63'b0, ms[3]} << 7) | ({62'b0, priv} << 11);
        base = mtvec & ~64'h3;
        tgt  = (mtvec[1:0] == 2'b01 && cause[63]) ? base + (cause << 2) : base;
        push("accept", mk(0, 0, 0, 12'h0, 64'h0, 0, 64'h0, 0, 2'b00));
        push("t_flush", mk(1, 1, 0, 12'h0, 64'h0, 0, 64'h0, 0, 2'b00));
        push("t_epc", mk(1, 0, 1, 12'h341, pc & ~64'h3, 0, 64'h0, 0, 2'b00));
        push("t_cause", mk(1, 0, 1, 12'h342, cause, 0, 64'h0, 0, 2'b00));
        push("t_tval", mk(1, 0, 1, 12'h343, tval, 0, 64'h0, 0, 2'b00));
        push("t_status", mk(1, 0, 1, 12'h300, st, 0, 64'h0, 0, 2'b00));
        push("t_jump", mk(1, 0, 0, 12'h0, 64'h0, 1, tgt, 1, 2'b11));
    endtask

    task automatic do_trap(input logic [63:0] cause, input logic [63:0] pc, input logic [63:0] tval,
                           input logic [63:0] mtvec, input logic [63:0] ms, input logic [1:0] priv,
                           input logic with_mret, input logic hold);
        drive_trap(cause, pc, tval, mtvec, ms, priv, with_mret);
        for (int i = 1; i <= 7; i++) begin
            @(posedge CLK); #1;
            if (i == 1) scramble();
            if ((i == 1 && !hold) || i == 6) begin TRAP_REQ = 1'b0; MRET_REQ = 1'b0; end
        end
    endtask

    task automatic do_mret(input logic [63:0] ms, input logic [63:0] mepc);
        logic [63:0] st;
        TRAP_REQ = 1'b0; MRET_REQ = 1'b1; MSTATUS = ms; MEPC = mepc;
        st = (ms & ~64'h1888) | ({63'b0, ms[7]} << 3) | 64'h80;
        push("accept", mk(0, 0, 0, 12'h0, 64'h0, 0, 64'h0, 0, 2'b00));
        push("r_status", mk(1, 1, 1, 12'h300, st, 0, 64'h0, 0, 2'b00));
        push("r_jump", mk(1, 0, 0, 12'h0, 64'h0, 1, mepc, 1, ms[12:11]));
        for (int i = 1; i <= 3; i++) begin
            @(posedge CLK); #1;
            if (i == 1) begin scramble(); MRET_REQ = 1'b0; end
        end
    endtask

    task automatic release_reset();
        RESET = 1'b0;
        push("post_reset_priv", mk(0, 0, 0, 12'h0, 64'h0, 0, 64'h0, 1, 2'b11));
        @(posedge CLK); #1;
    endtask

    initial begin
        @(posedge CLK); #1;
        mon_en = 1'b1;
        @(posedge CLK); #1;
        release_reset();
        do_trap(64'h2, 64'h8000_0106, 64'h13, 64'h100, 64'h8, 2'b00, 1'b0, 1'b0);
        do_trap(64'h8000_0000_0000_0007, 64'h1000, 64'h0, 64'h201, 64'h0, 2'b01, 1'b0, 1'b0);
        do_trap(64'h5, 64'h2002, 64'h0, 64'h201, 64'h88, 2'b11, 1'b0, 1'b0);
        do_mret(64'h1880, 64'h4000);
        do_mret(64'h0808, 64'h1234_5678_9abc_def0);
        do_trap(64'hb, 64'h3007, 64'h44, 64'h400, 64'h1808, 2'b11, 1'b1, 1'b1);
        @(posedge CLK); #1;
        for (int n = 0; n < 6; n++) begin
            logic [63:0] c, mt;
            c  = {$urandom, $urandom};
            mt = {$urandom, $urandom};
            mt[1:0] = 2'($urandom_range(0, 1));
            if (n % 2 == 0) do_trap(c, {$urandom, $urandom}, {$urandom, $urandom}, mt, {$urandom, $urandom}, 2'($urandom), 1'b0, n == 2);
            else do_mret({$urandom, $urandom}, {$urandom, $urandom});
        end
        drive_trap(64'h3, 64'h5000, 64'h77, 64'h100, 64'h8, 2'b00, 1'b0);
        repeat (3) begin @(posedge CLK); #1; TRAP_REQ = 1'b0; end
        RESET = 1'b1;
        eq = eq[0:0];
        tq = tq[0:0];
        @(posedge CLK); #1;
        @(posedge CLK); #1;
        release_reset();
        do_trap(64'h8000_0000_0000_0003, 64'h6004, 64'h0, 64'h301, 64'h8, 2'b00, 1'b0, 1'b0);
        repeat (3) @(posedge CLK);
        for (int k = 0; k < 20 && eq.size() != 0; k++) @(posedge CLK);
        if (eq.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d expectations left, required 0", eq.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
